// File: rtl/branch_rs.sv
// ============================================================================
// Module   : branch_rs
// Purpose  : Branch reservation station. Compacting queue (entry 0 oldest)
//            that holds up to RS_DEPTH branch/jump ops until both sources are
//            available, captures operands from two CDB ports, and issues the
//            oldest ready op to the branch unit once per cycle.
// Options  : BRANCH_RS_WAKEUP_BYPASS_EN - when defined, a CDB broadcast that
//            completes an entry makes it issuable in the same cycle, with the
//            broadcast value forwarded to the issue outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_rs #(
   parameter int RS_DEPTH     = 4,
   parameter int XLEN         = 32,
   parameter int PREG_NUMBER  = 64,
   parameter int DEST_REG_SEL = 2,
   localparam int TW          = $clog2(PREG_NUMBER),
   localparam int CW          = $clog2(RS_DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [1:0]                   dispatch_valid_i,
   input  logic [1:0][TW-1:0]           dispatch_rs1_tag_i,
   input  logic [1:0][TW-1:0]           dispatch_rs2_tag_i,
   input  logic [1:0]                   dispatch_rs1_ready_i,
   input  logic [1:0]                   dispatch_rs2_ready_i,
   input  logic [1:0][XLEN-1:0]         dispatch_rs1_value_i,
   input  logic [1:0][XLEN-1:0]         dispatch_rs2_value_i,
   input  logic [1:0][XLEN-1:0]         dispatch_opa_i,
   input  logic [1:0][XLEN-1:0]         dispatch_opb_i,
   input  logic [1:0]                   dispatch_opa_rs1_i,
   input  logic [1:0][TW-1:0]           dispatch_dest_tag_i,
   input  logic [1:0][DEST_REG_SEL-1:0] dispatch_dest_sel_i,
   input  logic [1:0][2:0]              dispatch_func_i,
   input  logic [1:0][6:0]              dispatch_opcode_i,
   input  logic [1:0][XLEN-1:0]         dispatch_pc_i,
   input  logic [1:0][XLEN-1:0]         dispatch_npc_i,
   input  logic [1:0]                   cdb_valid_i,
   input  logic [1:0][TW-1:0]           cdb_tag_i,
   input  logic [1:0][XLEN-1:0]         cdb_value_i,
   input  logic                         blu_ready_i,
   input  logic [1:0]                   branch_recover_i,
   output logic [CW-1:0]                free_slots_o,
   output logic                         issue_en_o,
   output logic [XLEN-1:0]              issue_opa_o,
   output logic [XLEN-1:0]              issue_opb_o,
   output logic [XLEN-1:0]              issue_rs1_o,
   output logic [XLEN-1:0]              issue_rs2_o,
   output logic [XLEN-1:0]              issue_pc_o,
   output logic [XLEN-1:0]              issue_npc_o,
   output logic [TW-1:0]                issue_dest_tag_o,
   output logic [DEST_REG_SEL-1:0]      issue_dest_sel_o,
   output logic [2:0]                   issue_func_o,
   output logic [6:0]                   issue_opcode_o
);

   localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   typedef struct packed {
      logic [TW-1:0]           rs1_tag;
      logic [TW-1:0]           rs2_tag;
      logic                    rs1_rdy;
      logic                    rs2_rdy;
      logic [XLEN-1:0]         rs1_val;
      logic [XLEN-1:0]         rs2_val;
      logic [XLEN-1:0]         opa;
      logic [XLEN-1:0]         opb;
      logic                    opa_rs1;
      logic [TW-1:0]           dest_tag;
      logic [DEST_REG_SEL-1:0] dest_sel;
      logic [2:0]              func;
      logic [6:0]              opcode;
      logic [XLEN-1:0]         pc;
      logic [XLEN-1:0]         npc;
   } entry_t;

   // Marks a waiting source ready with the CDB value; port 0 has priority.
   function automatic entry_t wake(input entry_t e,
                                   input logic [1:0] cv,
                                   input logic [1:0][TW-1:0] ct,
                                   input logic [1:0][XLEN-1:0] cval);
      entry_t r;
      r = e;
      if (!e.rs1_rdy) begin
         if (cv[0] && ct[0] == e.rs1_tag) begin
            r.rs1_rdy = 1'b1;
            r.rs1_val = cval[0];
         end else if (cv[1] && ct[1] == e.rs1_tag) begin
            r.rs1_rdy = 1'b1;
            r.rs1_val = cval[1];
         end
      end
      if (!e.rs2_rdy) begin
         if (cv[0] && ct[0] == e.rs2_tag) begin
            r.rs2_rdy = 1'b1;
            r.rs2_val = cval[0];
         end else if (cv[1] && ct[1] == e.rs2_tag) begin
            r.rs2_rdy = 1'b1;
            r.rs2_val = cval[1];
         end
      end
      return r;
   endfunction

   entry_t            entries   [RS_DEPTH];
   entry_t            eff       [RS_DEPTH];
   entry_t            shifted   [RS_DEPTH];
   entry_t            nxt       [RS_DEPTH];
   entry_t            new_op    [2];
   entry_t            sel;
   logic [RS_DEPTH-1:0] ready;
   logic              has_cand;
   logic [IW-1:0]     cand;
   logic [CW-1:0]     count;
   logic [CW-1:0]     post_cnt;
   logic [CW-1:0]     ndisp;
   logic [CW-1:0]     nxt_cnt;
   logic [CW-1:0]     pos0;
   logic [CW-1:0]     pos1;
   logic              unused_recover;

   assign unused_recover = branch_recover_i[1];
   assign count          = CW'(RS_DEPTH) - free_slots_o;
   assign ndisp          = CW'(dispatch_valid_i[0]) + CW'(dispatch_valid_i[1]);

   // Candidate view of each entry and oldest-ready selection.
   always_comb begin
      has_cand = 1'b0;
      cand     = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
         eff[i] = wake(entries[i], cdb_valid_i, cdb_tag_i, cdb_value_i);
`else
         eff[i] = entries[i];
`endif
         ready[i] = (CW'(i) < count) && eff[i].rs1_rdy && eff[i].rs2_rdy;
      end
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (ready[i]) begin
            has_cand = 1'b1;
            cand     = IW'(i);
         end
      end
   end

   assign issue_en_o = blu_ready_i & has_cand & ~branch_recover_i[0] & ~reset;

   // Issue fields come straight from the selected entry (entry 0 when idle).
   always_comb begin
      sel              = eff[cand];
      issue_opa_o      = sel.opa_rs1 ? sel.rs1_val : sel.opa;
      issue_opb_o      = sel.opb;
      issue_rs1_o      = sel.rs1_val;
      issue_rs2_o      = sel.rs2_val;
      issue_pc_o       = sel.pc;
      issue_npc_o      = sel.npc;
      issue_dest_tag_o = sel.dest_tag;
      issue_dest_sel_o = sel.dest_sel;
      issue_func_o     = sel.func;
      issue_opcode_o   = sel.opcode;
   end

   // Next queue image: close the gap left by issue, wake, then append dispatch.
   always_comb begin
      post_cnt = count - CW'(issue_en_o);
      pos0     = post_cnt;
      pos1     = post_cnt + CW'(dispatch_valid_i[0]);
      nxt_cnt  = post_cnt + ndisp;
      for (int s = 0; s < 2; s++) begin
         new_op[s].rs1_tag  = dispatch_rs1_tag_i[s];
         new_op[s].rs2_tag  = dispatch_rs2_tag_i[s];
         new_op[s].rs1_rdy  = dispatch_rs1_ready_i[s];
         new_op[s].rs2_rdy  = dispatch_rs2_ready_i[s];
         new_op[s].rs1_val  = dispatch_rs1_value_i[s];
         new_op[s].rs2_val  = dispatch_rs2_value_i[s];
         new_op[s].opa      = dispatch_opa_i[s];
         new_op[s].opb      = dispatch_opb_i[s];
         new_op[s].opa_rs1  = dispatch_opa_rs1_i[s];
         new_op[s].dest_tag = dispatch_dest_tag_i[s];
         new_op[s].dest_sel = dispatch_dest_sel_i[s];
         new_op[s].func     = dispatch_func_i[s];
         new_op[s].opcode   = dispatch_opcode_i[s];
         new_op[s].pc       = dispatch_pc_i[s];
         new_op[s].npc      = dispatch_npc_i[s];
         new_op[s] = wake(new_op[s], cdb_valid_i, cdb_tag_i, cdb_value_i);
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
         int src;
         src = (issue_en_o && (i >= int'(cand))) ? i + 1 : i;
         if (src < RS_DEPTH) shifted[i] = entries[src];
         else                shifted[i] = '0;
         nxt[i] = wake(shifted[i], cdb_valid_i, cdb_tag_i, cdb_value_i);
         if (dispatch_valid_i[0] && CW'(i) == pos0) nxt[i] = new_op[0];
         if (dispatch_valid_i[1] && CW'(i) == pos1) nxt[i] = new_op[1];
      end
   end

   // Queue storage and occupancy; flush and reset empty the queue.
   always_ff @(posedge clk) begin
      if (reset || branch_recover_i[0]) begin
         free_slots_o <= CW'(RS_DEPTH);
      end else begin
         free_slots_o <= CW'(RS_DEPTH) - nxt_cnt;
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
         entries[i] <= nxt[i];
      end
   end

   // Dispatch must never exceed the advertised free entries.
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !branch_recover_i[0] |-> (ndisp <= free_slots_o));

endmodule

`default_nettype wire

// File: tb/tb_branch_rs.sv
// ============================================================================
// Module   : tb_branch_rs
// Purpose  : Directed self-checking bench for branch_rs (RS_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_rs;

   logic             clk;
   logic             reset;
   logic [1:0]       dispatch_valid;
   logic [1:0][5:0]  dispatch_rs1_tag, dispatch_rs2_tag;
   logic [1:0]       dispatch_rs1_ready, dispatch_rs2_ready;
   logic [1:0][31:0] dispatch_rs1_value, dispatch_rs2_value;
   logic [1:0][31:0] dispatch_opa, dispatch_opb;
   logic [1:0]       dispatch_opa_rs1;
   logic [1:0][5:0]  dispatch_dest_tag;
   logic [1:0][1:0]  dispatch_dest_sel;
   logic [1:0][2:0]  dispatch_func;
   logic [1:0][6:0]  dispatch_opcode;
   logic [1:0][31:0] dispatch_pc, dispatch_npc;
   logic [1:0]       cdb_valid;
   logic [1:0][5:0]  cdb_tag;
   logic [1:0][31:0] cdb_value;
   logic             blu_ready;
   logic [1:0]       branch_recover;
   logic [2:0]       free_slots;
   logic             issue_en;
   logic [31:0]      issue_opa, issue_opb, issue_rs1, issue_rs2, issue_pc, issue_npc;
   logic [5:0]       issue_dest_tag;
   logic [1:0]       issue_dest_sel;
   logic [2:0]       issue_func;
   logic [6:0]       issue_opcode;

   int n_vec = 0;
   int n_err = 0;

   branch_rs dut (
      .clk                  (clk),
      .reset                (reset),
      .dispatch_valid_i     (dispatch_valid),
      .dispatch_rs1_tag_i   (dispatch_rs1_tag),
      .dispatch_rs2_tag_i   (dispatch_rs2_tag),
      .dispatch_rs1_ready_i (dispatch_rs1_ready),
      .dispatch_rs2_ready_i (dispatch_rs2_ready),
      .dispatch_rs1_value_i (dispatch_rs1_value),
      .dispatch_rs2_value_i (dispatch_rs2_value),
      .dispatch_opa_i       (dispatch_opa),
      .dispatch_opb_i       (dispatch_opb),
      .dispatch_opa_rs1_i   (dispatch_opa_rs1),
      .dispatch_dest_tag_i  (dispatch_dest_tag),
      .dispatch_dest_sel_i  (dispatch_dest_sel),
      .dispatch_func_i      (dispatch_func),
      .dispatch_opcode_i    (dispatch_opcode),
      .dispatch_pc_i        (dispatch_pc),
      .dispatch_npc_i       (dispatch_npc),
      .cdb_valid_i          (cdb_valid),
      .cdb_tag_i            (cdb_tag),
      .cdb_value_i          (cdb_value),
      .blu_ready_i          (blu_ready),
      .branch_recover_i     (branch_recover),
      .free_slots_o         (free_slots),
      .issue_en_o           (issue_en),
      .issue_opa_o          (issue_opa),
      .issue_opb_o          (issue_opb),
      .issue_rs1_o          (issue_rs1),
      .issue_rs2_o          (issue_rs2),
      .issue_pc_o           (issue_pc),
      .issue_npc_o          (issue_npc),
      .issue_dest_tag_o     (issue_dest_tag),
      .issue_dest_sel_o     (issue_dest_sel),
      .issue_func_o         (issue_func),
      .issue_opcode_o       (issue_opcode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dispatch_valid = 2'b00;
      cdb_valid      = 2'b00;
      branch_recover = 2'b00;
   endtask

   task automatic disp(input int s, input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                       input logic [5:0] t2, input logic r2, input logic [31:0] v2,
                       input logic jalr, input logic [31:0] pc);
      dispatch_valid[s]     = 1'b1;
      dispatch_rs1_tag[s]   = t1;
      dispatch_rs1_ready[s] = r1;
      dispatch_rs1_value[s] = v1;
      dispatch_rs2_tag[s]   = t2;
      dispatch_rs2_ready[s] = r2;
      dispatch_rs2_value[s] = v2;
      dispatch_opa[s]       = pc;
      dispatch_opb[s]       = 32'h40;
      dispatch_opa_rs1[s]   = jalr;
      dispatch_dest_tag[s]  = pc[7:2];
      dispatch_dest_sel[s]  = 2'b01;
      dispatch_func[s]      = pc[4:2];
      dispatch_opcode[s]    = jalr ? 7'h67 : 7'h63;
      dispatch_pc[s]        = pc;
      dispatch_npc[s]       = pc + 32'd4;
   endtask

   task automatic cdb(input int p, input logic [5:0] t, input logic [31:0] v);
      cdb_valid[p] = 1'b1;
      cdb_tag[p]   = t;
      cdb_value[p] = v;
   endtask

   initial begin
      reset = 1'b1;
      blu_ready = 1'b0;
      dispatch_rs1_tag = '0; dispatch_rs2_tag = '0;
      dispatch_rs1_ready = '0; dispatch_rs2_ready = '0;
      dispatch_rs1_value = '0; dispatch_rs2_value = '0;
      dispatch_opa = '0; dispatch_opb = '0; dispatch_opa_rs1 = '0;
      dispatch_dest_tag = '0; dispatch_dest_sel = '0; dispatch_func = '0;
      dispatch_opcode = '0; dispatch_pc = '0; dispatch_npc = '0;
      cdb_tag = '0; cdb_value = '0;
      idle_inputs();
      tick(); tick();
      reset = 1'b0;
      #1;
      check("reset_free", 64'(free_slots), 64'd4);
      check("reset_issue", 64'(issue_en), 64'd0);

      // Single BEQ, both sources ready
      blu_ready = 1'b1;
      disp(0, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22, 1'b0, 32'h1000);
      #1;
      check("beq_no_same_cycle", 64'(issue_en), 64'd0);
      tick(); idle_inputs(); #1;
      check("beq_free3", 64'(free_slots), 64'd3);
      check("beq_issue", 64'(issue_en), 64'd1);
      check("beq_rs1", 64'(issue_rs1), 64'h11);
      check("beq_rs2", 64'(issue_rs2), 64'h22);
      check("beq_pc", 64'(issue_pc), 64'h1000);
      check("beq_npc", 64'(issue_npc), 64'h1004);
      check("beq_opa", 64'(issue_opa), 64'h1000);
      check("beq_opb", 64'(issue_opb), 64'h40);
      check("beq_opcode", 64'(issue_opcode), 64'h63);
      check("beq_dest", 64'(issue_dest_tag), 64'h00);
      check("beq_sel", 64'(issue_dest_sel), 64'h1);
      tick(); #1;
      check("beq_free4", 64'(free_slots), 64'd4);
      check("beq_idle", 64'(issue_en), 64'd0);

      // A waits on tag 5, younger B ready: B first, then A after wakeup
      disp(0, 6'd5, 1'b0, 32'h0, 6'd3, 1'b1, 32'h33, 1'b0, 32'h2000);
      disp(1, 6'd4, 1'b1, 32'h44, 6'd3, 1'b1, 32'h33, 1'b0, 32'h2004);
      tick(); idle_inputs(); #1;
      check("ooo_free2", 64'(free_slots), 64'd2);
      check("ooo_issue_b", 64'(issue_en), 64'd1);
      check("ooo_pc_b", 64'(issue_pc), 64'h2004);
      tick();
      cdb(0, 6'd5, 32'h10); #1;
      check("ooo_free3", 64'(free_slots), 64'd3);
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
      check("ooo_byp_issue", 64'(issue_en), 64'd1);
      check("ooo_byp_rs1", 64'(issue_rs1), 64'h10);
      check("ooo_byp_pc", 64'(issue_pc), 64'h2000);
      tick(); idle_inputs(); #1;
      check("ooo_byp_free4", 64'(free_slots), 64'd4);
`else
      check("ooo_wait", 64'(issue_en), 64'd0);
      tick(); idle_inputs(); #1;
      check("ooo_issue_a", 64'(issue_en), 64'd1);
      check("ooo_rs1_a", 64'(issue_rs1), 64'h10);
      check("ooo_pc_a", 64'(issue_pc), 64'h2000);
      tick(); #1;
      check("ooo_free4", 64'(free_slots), 64'd4);
`endif
      check("ooo_done", 64'(issue_en), 64'd0);

      // Fill all four entries while the branch unit stalls
      blu_ready = 1'b0;
      disp(0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h3000);
      disp(1, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h3004);
      tick();
      disp(0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h3008);
      disp(1, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h300C);
      tick(); idle_inputs(); #1;
      check("full_free0", 64'(free_slots), 64'd0);
      check("full_stall", 64'(issue_en), 64'd0);
      blu_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("full_issue", 64'(issue_en), 64'd1);
         check("full_order", 64'(issue_pc), 64'(32'h3000 + 32'(4 * k)));
         check("full_free", 64'(free_slots), 64'(k));
         tick();
      end
      #1;
      check("full_drained", 64'(free_slots), 64'd4);
      check("full_idle", 64'(issue_en), 64'd0);

      // JALR: opa replaced by rs1; both CDB ports carry tag 9, port 0 wins
      disp(0, 6'd9, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 1'b1, 32'h4000);
      tick(); idle_inputs(); #1;
      check("jalr_wait", 64'(issue_en), 64'd0);
      cdb(0, 6'd9, 32'h8000);
      cdb(1, 6'd9, 32'h1234);
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
      #1;
`else
      tick(); idle_inputs(); #1;
`endif
      check("jalr_issue", 64'(issue_en), 64'd1);
      check("jalr_opa", 64'(issue_opa), 64'h8000);
      check("jalr_rs1", 64'(issue_rs1), 64'h8000);
      check("jalr_opcode", 64'(issue_opcode), 64'h67);
      tick(); idle_inputs(); #1;
      check("jalr_free4", 64'(free_slots), 64'd4);

      // Flush with three valid entries, concurrent dispatch and ready unit
      blu_ready = 1'b0;
      disp(0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h5000);
      disp(1, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h5004);
      tick(); idle_inputs();
      disp(0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h5008);
      tick(); idle_inputs(); #1;
      check("flush_pre_free1", 64'(free_slots), 64'd1);
      blu_ready = 1'b1;
      branch_recover = 2'b01;
      disp(0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h500C);
      #1;
      check("flush_no_issue", 64'(issue_en), 64'd0);
      tick(); idle_inputs(); #1;
      check("flush_free4", 64'(free_slots), 64'd4);
      check("flush_empty", 64'(issue_en), 64'd0);
      tick(); #1;
      check("flush_still_empty", 64'(issue_en), 64'd0);

      // Dispatch-cycle capture of a CDB broadcast
      disp(0, 6'd7, 1'b0, 32'h0, 6'd8, 1'b1, 32'h99, 1'b0, 32'h6000);
      cdb(0, 6'd7, 32'h2A);
      tick(); idle_inputs(); #1;
      check("cap_issue", 64'(issue_en), 64'd1);
      check("cap_rs1", 64'(issue_rs1), 64'h2A);
      check("cap_rs2", 64'(issue_rs2), 64'h99);
      tick(); #1;
      check("cap_free4", 64'(free_slots), 64'd4);

      // Issue, two dispatches and a wakeup of a shifted entry in one cycle
      blu_ready = 1'b0;
      disp(0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h7000);
      disp(1, 6'd1, 1'b1, 32'h1, 6'd12, 1'b0, 32'h0, 1'b0, 32'h7004);
      tick(); idle_inputs();
      blu_ready = 1'b1;
      disp(0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h7008);
      disp(1, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h700C);
      cdb(1, 6'd12, 32'h55);
      #1;
      check("mix_issue_x", 64'(issue_pc), 64'h7000);
      tick(); idle_inputs(); #1;
      check("mix_free1", 64'(free_slots), 64'd1);
      check("mix_issue_y", 64'(issue_pc), 64'h7004);
      check("mix_rs2_y", 64'(issue_rs2), 64'h55);
      tick(); #1;
      check("mix_issue_z", 64'(issue_pc), 64'h7008);
      tick(); #1;
      check("mix_issue_w", 64'(issue_pc), 64'h700C);
      check("mix_en_w", 64'(issue_en), 64'd1);
      tick(); #1;
      check("mix_free4", 64'(free_slots), 64'd4);

      // Reset mid-operation empties the queue
      blu_ready = 1'b0;
      disp(0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 1'b0, 32'h8000);
      tick(); idle_inputs();
      reset = 1'b1;
      blu_ready = 1'b1;
      #1;
      check("rst_mid_no_issue", 64'(issue_en), 64'd0);
      tick(); reset = 1'b0; #1;
      check("rst_mid_free4", 64'(free_slots), 64'd4);
      check("rst_mid_empty", 64'(issue_en), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/branch_rs.md
# branch_rs

Branch reservation station directly upstream of the branch logic unit. Accepts up to two branch/jump micro-ops per cycle from dispatch, holds them until both source operands are available (capturing values from the two CDB broadcast ports), and issues at most one ready op per cycle to the branch unit when it signals ready. Selection is oldest-ready-first. All entries are flushed on branch recovery.

## Interface
- RS_DEPTH, 4, number of entries (≥2)
- XLEN, 32, data width
- PREG_NUMBER, 64, physical registers; TW = clog2(PREG_NUMBER)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dispatch_valid_i  in  2  per-slot dispatch strobe; slot 0 older than slot 1
- dispatch_rs1_tag_i / dispatch_rs2_tag_i  in  2×TW  source physical tags
- dispatch_rs1_ready_i / dispatch_rs2_ready_i  in  2  source value already valid
- dispatch_rs1_value_i / dispatch_rs2_value_i  in  2×XLEN  source values (meaningful when ready)
- dispatch_opa_i / dispatch_opb_i  in  2×XLEN  target operands (PC/immediate)
- dispatch_opa_rs1_i  in  2  opa is replaced by rs1 value at issue (JALR)
- dispatch_dest_tag_i  in  2×TW  destination tag; dispatch_dest_sel_i  in  2×DEST_REG_SEL
- dispatch_func_i  in  2×3  funct3; dispatch_opcode_i  in  2×7; dispatch_pc_i / dispatch_npc_i  in  2×XLEN
- cdb_valid_i  in  2; cdb_tag_i  in  2×TW; cdb_value_i  in  2×XLEN  completion broadcasts
- blu_ready_i  in  1  branch unit can accept an op this cycle
- branch_recover_i  in  2  bit 0 = flush
- free_slots_o  out  clog2(RS_DEPTH+1)  registered count of empty entries
- issue_en_o  out  1  op presented this cycle is taken
- issue_opa_o, issue_opb_o, issue_rs1_o, issue_rs2_o, issue_pc_o, issue_npc_o  out  XLEN each
- issue_dest_tag_o  out  TW; issue_dest_sel_o  out  DEST_REG_SEL; issue_func_o  out  3; issue_opcode_o  out  7

## Operation
- Storage: compacting queue, entry 0 oldest; valid entries always occupy indices 0..count-1.
- Entry ready = rs1_ready & rs2_ready. Issue candidate = lowest-index ready entry.
- issue_en_o = blu_ready_i & candidate exists & ~branch_recover_i[0]; issue outputs combinationally driven from candidate (opa replaced by rs1 value if opa_rs1 set). Outputs are don't-care-but-stable (candidate or entry 0) when issue_en_o=0.
- On issue, entries above the issued index shift down one place at the clock edge; dispatched ops append after the post-shift tail, slot 0 before slot 1; if only slot 1 valid it takes the first free position.
- Wakeup: any valid entry whose unready source tag equals a valid CDB tag sets ready and captures value at the edge. Both CDB ports checked per source; matching both ports with same tag is legal, port 0 wins.
- Dispatch capture: a dispatched source with ready=0 whose tag matches a CDB broadcast in the dispatch cycle is stored ready with the CDB value.
- Flush (branch_recover_i[0]=1): all entries invalidated at the edge; same-cycle dispatch dropped; no issue that cycle; free_slots_o = RS_DEPTH next cycle.
- Dispatch of more ops than free_slots_o is a protocol violation (assertion), not handled.

## Timing
- Reset: all entries invalid, free_slots_o=RS_DEPTH, issue_en_o=0.
- Minimum dispatch→issue latency 1 cycle (op with both sources ready dispatched cycle N issues N+1 earliest).
- CDB in cycle N wakes entry; entry issuable cycle N+1 (see Configuration).
- free_slots_o reflects state after the previous edge; a slot freed by issue in cycle N is usable by dispatch in N+1.
- Simultaneous issue + 2 dispatches + CDB wakeup in one cycle must all take effect consistently (wakeup applied to shifted entries).
- Reset mid-operation behaves as flush plus output reset.

## Configuration
- BRANCH_RS_WAKEUP_BYPASS_EN defined: an entry whose last missing source matches a CDB broadcast in cycle N is an issue candidate in cycle N, with CDB value forwarded to issue_rs1_o/issue_rs2_o (and opa if opa_rs1). Age priority unchanged.
- Undefined: wakeup takes effect only at the edge; entry issuable from N+1. Dispatch-cycle capture is present in both builds.

## Test plan
- Reset, dispatch one BEQ with both sources ready, blu_ready_i=1 -> issue_en_o=1 next cycle with matching fields; free_slots_o 4→3→4.
- Dispatch A (rs1 tag 5 unready) then B (ready); -> B issues first; CDB tag 5 value 0x10 -> A issues with issue_rs1_o=0x10 next cycle (same cycle with bypass macro).
- Fill 4 entries all ready, blu_ready_i=0 -> free_slots_o=0, no issue; raise blu_ready_i -> issue in dispatch order, one per cycle.
- JALR with opa_rs1=1, rs1 tag 9 woken with 0x8000 -> issue_opa_o=0x8000.
- 3 entries valid, branch_recover_i[0]=1 with concurrent dispatch and blu_ready_i=1 -> issue_en_o=0, next cycle free_slots_o=4, nothing issues.
- Dispatch with unready tag 7 while CDB broadcasts tag 7 value 0x2A same cycle -> entry stored ready, issues next cycle with 0x2A.
